// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer on the LSU load/store bus.
// Loads are answered combinationally; stores take effect on the next rising edge.
// Optional capture input enabled by defining MMIO_TIMER_CAPTURE_EN.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_7100,
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic        i_capture,
    output logic        o_sel,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

`ifdef MMIO_TIMER_CAPTURE_EN
    localparam int CTRL_W = 4;
    localparam int STAT_W = 2;
`else
    localparam int CTRL_W = 3;
    localparam int STAT_W = 1;
`endif

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_PSC     = 3'd1;
    localparam logic [2:0] OFF_COUNT   = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    logic [2:0]            off;
    logic [3:0]            lane_en;
    logic [31:0]           lane_data;
    logic [31:0]           bmask;
    logic                  acc_ok;
    logic                  wr;
    logic                  wr_ctrl, wr_psc, wr_count, wr_compare, wr_status;

    logic [CTRL_W-1:0]     ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic [STAT_W-1:0]     status;
    logic [STAT_W-1:0]     st_set;
    logic [STAT_W-1:0]     st_clr;

    logic                  tick;
    logic                  hit;
    logic                  match_set;

    assign off   = i_lsu_addr[4:2];
    assign o_sel = (i_lsu_addr[31:5] == BASE_ADDR[31:5]);

    // Byte-lane enables and lane-replicated store data; misaligned accesses are rejected
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = i_lsu_data;
        acc_ok    = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                acc_ok    = 1'b1;
                lane_en   = 4'b0001 << i_lsu_addr[1:0];
                lane_data = {4{i_lsu_data[7:0]}};
            end
            2'b01: begin
                acc_ok    = ~i_lsu_addr[0];
                lane_en   = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_lsu_data[15:0]}};
            end
            2'b10: begin
                acc_ok  = (i_lsu_addr[1:0] == 2'b00);
                lane_en = 4'b1111;
            end
            default: begin
                acc_ok = 1'b0;
            end
        endcase
    end

    assign bmask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
    assign wr    = i_lsu_wren & o_sel & acc_ok;

    assign wr_ctrl    = wr & (off == OFF_CTRL);
    assign wr_psc     = wr & (off == OFF_PSC);
    assign wr_count   = wr & (off == OFF_COUNT);
    assign wr_compare = wr & (off == OFF_COMPARE);
    assign wr_status  = wr & (off == OFF_STATUS);

    assign tick      = ctrl[0] & (psc == prescale);
    assign hit       = (count == compare);
    // A CPU write to COUNT in a tick cycle suppresses that cycle's match
    assign match_set = tick & hit & ~wr_count;
    assign st_clr    = wr_status ? (lane_data[STAT_W-1:0] & bmask[STAT_W-1:0]) : '0;

    // Software-visible configuration registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= RST_COMPARE;
        end else begin
            if (wr_ctrl)
                ctrl <= (ctrl & ~bmask[CTRL_W-1:0]) | (lane_data[CTRL_W-1:0] & bmask[CTRL_W-1:0]);
            if (wr_psc)
                prescale <= (prescale & ~bmask[PRESCALE_W-1:0]) |
                            (lane_data[PRESCALE_W-1:0] & bmask[PRESCALE_W-1:0]);
            if (wr_compare)
                compare <= (compare & ~bmask) | (lane_data & bmask);
        end
    end

    // Prescaler: free-runs while enabled, restarts on tick, disable, or PRESCALE write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            psc <= '0;
        else if (wr_psc || !ctrl[0] || tick)
            psc <= '0;
        else
            psc <= psc + PRESCALE_W'(1);
    end

    // Main counter: CPU write beats tick; on match optionally reload to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            count <= '0;
        else if (wr_count)
            count <= (count & ~bmask) | (lane_data & bmask);
        else if (tick)
            count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;
    end

    // Sticky status: write-1-to-clear, a same-cycle set wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            status <= '0;
        else
            status <= (status & ~st_clr) | st_set;
    end

`ifdef MMIO_TIMER_CAPTURE_EN
    logic [2:0]  cap_sync;
    logic        cap_rise;
    logic [31:0] capture;
    logic        unused_bits;

    assign cap_rise = cap_sync[1] & ~cap_sync[2];
    assign st_set   = {cap_rise, match_set};
    assign o_irq    = (status[0] & ctrl[2]) | (status[1] & ctrl[3]);
    assign unused_bits = &{1'b0, i_funct3[2]};

    // Two-flop synchronizer plus edge register for the external capture pin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cap_sync <= '0;
        else
            cap_sync <= {cap_sync[1:0], i_capture};
    end

    // Snapshot of COUNT as it stood before this cycle's update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            capture <= '0;
        else if (cap_rise)
            capture <= count;
    end
`else
    logic unused_bits;

    assign st_set      = match_set;
    assign o_irq       = status[0] & ctrl[2];
    assign unused_bits = &{1'b0, i_capture, i_funct3[2]};
`endif

    // Combinational read mux; unmapped offsets and bits read zero
    always_comb begin
        o_rdata = 32'd0;
        if (o_sel) begin
            case (off)
                OFF_CTRL:    o_rdata[CTRL_W-1:0]     = ctrl;
                OFF_PSC:     o_rdata[PRESCALE_W-1:0] = prescale;
                OFF_COUNT:   o_rdata                 = count;
                OFF_COMPARE: o_rdata                 = compare;
                OFF_STATUS:  o_rdata[STAT_W-1:0]     = status;
`ifdef MMIO_TIMER_CAPTURE_EN
                3'd5:        o_rdata                 = capture;
`endif
                default:     o_rdata                 = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer against a register-level reference model.
module tb_mmio_timer;
    localparam logic [31:0] BASE = 32'h0000_7100;
`ifdef MMIO_TIMER_CAPTURE_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wren = 1'b0;
    logic [2:0]  f3 = 3'd2;
    logic        cap_in = 1'b0;
    logic        cap_next = 1'b0;
    logic        sel;
    logic [31:0] rdata;
    logic        irq;

    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16), .RST_COMPARE(32'hFFFF_FFFF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_lsu_data(wdata),
        .i_lsu_wren(wren), .i_funct3(f3), .i_capture(cap_in),
        .o_sel(sel), .o_rdata(rdata), .o_irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        sel;
        logic        irq;
    } exp_t;

    exp_t q[$];
    bit   mon_req = 1'b0;

    // Reference model state (register view)
    logic [3:0]  m_ctrl;
    logic [15:0] m_pre, m_psc;
    logic [31:0] m_cnt, m_cmp, m_cap;
    logic [1:0]  m_st;
    logic [2:0]  m_hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Store a sub-word or word into a 32-bit register image; ok=0 for dropped accesses
    function automatic logic [31:0] store(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic [2:0] f, output bit ok);
        logic [31:0] r;
        r  = old;
        ok = 1'b0;
        case (f[1:0])
            2'b00: begin ok = 1'b1; r[a[1:0]*8 +: 8] = d[7:0]; end
            2'b01: begin ok = !a[0]; r[a[1]*16 +: 16] = d[15:0]; end
            2'b10: begin ok = (a[1:0] == 2'b00); r = d; end
            default: ok = 1'b0;
        endcase
        return ok ? r : old;
    endfunction

    function automatic exp_t mk(input string name, input logic [31:0] a);
        exp_t e;
        e.name = name;
        e.sel  = (a[31:5] == BASE[31:5]);
        e.rd   = 32'd0;
        if (e.sel) begin
            case (a[4:2])
                3'd0: e.rd = {28'd0, m_ctrl};
                3'd1: e.rd = {16'd0, m_pre};
                3'd2: e.rd = m_cnt;
                3'd3: e.rd = m_cmp;
                3'd4: e.rd = {30'd0, m_st};
                3'd5: e.rd = FEAT ? m_cap : 32'd0;
                default: e.rd = 32'd0;
            endcase
        end
        e.irq = (m_st[0] & m_ctrl[2]) | (m_st[1] & m_ctrl[3]);
        return e;
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_pre = '0; m_psc = '0; m_cnt = '0;
        m_cmp = 32'hFFFF_FFFF; m_cap = '0; m_st = '0; m_hist = '0;
    endtask

    // Advance the model across one rising edge with the given bus activity
    task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        bit          ok, okc, wr, tick, eq, rise;
        logic [2:0]  o;
        logic [31:0] old, nv, clr, cnt_before;
        o = a[4:2];
        case (o)
            3'd0: old = {28'd0, m_ctrl};
            3'd1: old = {16'd0, m_pre};
            3'd2: old = m_cnt;
            3'd3: old = m_cmp;
            default: old = 32'd0;
        endcase
        nv  = store(old, a, d, f, ok);
        clr = store(32'd0, a, d, f, okc);
        wr  = we && (a[31:5] == BASE[31:5]) && ok;
        tick = m_ctrl[0] && (m_psc == m_pre);
        eq   = (m_cnt == m_cmp);
        rise = FEAT && m_hist[1] && !m_hist[2];
        cnt_before = m_cnt;

        if (wr && o == 3'd1)          m_psc = 16'd0;
        else if (m_ctrl[0] && !tick)  m_psc = m_psc + 16'd1;
        else                          m_psc = 16'd0;

        if (wr && o == 3'd2)  m_cnt = nv;
        else if (tick)        m_cnt = (eq && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;

        if (wr && o == 3'd4)  m_st = m_st & ~clr[1:0];
        if (tick && eq && !(wr && o == 3'd2)) m_st[0] = 1'b1;
        if (rise) begin m_st[1] = 1'b1; m_cap = cnt_before; end

        if (wr && o == 3'd0)  m_ctrl = FEAT ? nv[3:0] : {1'b0, nv[2:0]};
        if (wr && o == 3'd1)  m_pre = nv[15:0];
        if (wr && o == 3'd3)  m_cmp = nv;
        m_hist = {m_hist[1:0], cap_in};
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (mon_req) begin
            if (q.size() == 0) begin
                check("queue_empty", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check({e.name, "_rdata"}, rdata, e.rd);
                check({e.name, "_sel"}, {31'd0, sel}, {31'd0, e.sel});
                check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    task automatic op(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input string name);
        @(posedge clk); #1;
        wren = we; addr = a; wdata = d; f3 = f; cap_in = cap_next;
        q.push_back(mk(name, a));
        mon_req = 1'b1;
        model_step(we, a, d, f);
    endtask

    task automatic op_const(input logic [7:0] o, input logic [31:0] exp_rd, input bit exp_irq,
                            input string name);
        exp_t e;
        @(posedge clk); #1;
        wren = 1'b0; addr = BASE + {24'd0, o}; wdata = 32'd0; f3 = 3'd2; cap_in = cap_next;
        e.name = name; e.rd = exp_rd; e.sel = 1'b1; e.irq = exp_irq;
        q.push_back(e);
        mon_req = 1'b1;
        model_step(1'b0, addr, 32'd0, 3'd2);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        op(1'b1, BASE + {24'd0, o}, d, 3'd2, "wr");
    endtask

    task automatic rd(input logic [7:0] o);
        op(1'b0, BASE + {24'd0, o}, 32'd0, 3'd2, "rd");
    endtask

    // Asynchronous reset between edges, checked before any clock edge arrives
    task automatic do_reset(input string name);
        @(posedge clk); #1;
        mon_req = 1'b0; wren = 1'b0; wdata = '0; f3 = 3'd2; cap_next = 1'b0; cap_in = 1'b0;
        addr = BASE + 32'h8;
        rst_n = 1'b0;
        model_reset();
        #1 check({name, "_count"}, rdata, 32'd0);
        addr = BASE + 32'hC;
        #1 check({name, "_compare"}, rdata, 32'hFFFF_FFFF);
        check({name, "_irq"}, {31'd0, irq}, 32'd0);
        #1 rst_n = 1'b1;
        model_step(1'b0, addr, 32'd0, 3'd2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  o, f;
        logic [1:0]  lo;
        bit          we;
        model_reset();
        do_reset("init_rst");

        // Periodic reload: tick every 4 cycles, match at COUNT=4 on the fifth tick
        wr(8'h04, 32'd3); wr(8'h0C, 32'd4); wr(8'h00, 32'd7);
        repeat (20) rd(8'h08);
        op_const(8'h10, 32'd1, 1'b1, "reload_match");
        op_const(8'h08, 32'd0, 1'b1, "reload_count");
        wr(8'h10, 32'd1);
        op_const(8'h10, 32'd0, 1'b0, "w1c");

        // Sub-word stores
        wr(8'h00, 32'd0); wr(8'h0C, 32'd0);
        op(1'b1, BASE + 32'hE, 32'h0000_00AB, 3'd0, "sb");
        op_const(8'h0C, 32'h00AB_0000, 1'b0, "sb_cmp");
        op(1'b1, BASE + 32'hD, 32'h0000_1234, 3'd1, "sh_mis");
        op_const(8'h0C, 32'h00AB_0000, 1'b0, "sh_mis_cmp");
        op(1'b1, BASE + 32'hE, 32'hFFFF_FFFF, 3'd2, "sw_mis");
        op_const(8'h0C, 32'h00AB_0000, 1'b0, "sw_mis_cmp");

        // Write to COUNT in a tick cycle
        wr(8'h04, 32'd0); wr(8'h00, 32'd1); wr(8'h08, 32'h100);
        op_const(8'h08, 32'h100, 1'b0, "coll_0");
        op_const(8'h08, 32'h101, 1'b0, "coll_1");

        // Wrap without reload, later match at COUNT=5
        wr(8'h00, 32'd0); wr(8'h0C, 32'd5); wr(8'h08, 32'hFFFF_FFFF); wr(8'h10, 32'd3);
        wr(8'h00, 32'd1);
        op_const(8'h08, 32'hFFFF_FFFF, 1'b0, "wrap_pre");
        op_const(8'h08, 32'd0, 1'b0, "wrap_zero");
        op_const(8'h10, 32'd0, 1'b0, "wrap_nomatch");
        repeat (3) rd(8'h08);
        op_const(8'h08, 32'd5, 1'b0, "at_cmp");
        op_const(8'h08, 32'd6, 1'b0, "past_cmp");
        op_const(8'h10, 32'd1, 1'b0, "wrap_match");

        // Capture pulse while COUNT=0x20
        wr(8'h10, 32'd3); wr(8'h08, 32'h1E);
        op_const(8'h08, 32'h1E, 1'b0, "cap_c1e");
        op_const(8'h08, 32'h1F, 1'b0, "cap_c1f");
        cap_next = 1'b1;
        op_const(8'h08, 32'h20, 1'b0, "cap_c20");
        cap_next = 1'b0;
        rd(8'h08); rd(8'h08);
        op_const(8'h14, FEAT ? 32'h22 : 32'd0, 1'b0, "capture");
        op_const(8'h10, FEAT ? 32'd2 : 32'd0, 1'b0, "cap_flag");

        // Reset in the middle of counting
        wr(8'h04, 32'd100); wr(8'h08, 32'h55); wr(8'h00, 32'd5);
        op_const(8'h08, 32'h55, 1'b0, "pre_rst");
        do_reset("mid_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            o  = 3'($urandom_range(0, 7));
            lo = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            a  = BASE | {27'd0, o, lo};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            d = $urandom;
            if (o == 3'd1) d = $urandom_range(0, 3);
            if ((o == 3'd2 || o == 3'd3) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 12);
            f  = 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 1) == 1);
            cap_next = ($urandom_range(0, 3) == 0);
            op(we, a, d, f, "rand");
        end

        @(posedge clk); #1;
        mon_req = 1'b0; wren = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
